// File: rtl/reset_sequencer.sv
// Staged reset sequencer: stretches each incoming reset pulse, then releases
// NUM_STAGES downstream reset domains one by one, waiting for each to acknowledge.
module reset_sequencer #(
  parameter int unsigned STRETCH_CYCLES = 16,
  parameter int unsigned STAGE_GAP      = 8,
  parameter int unsigned NUM_STAGES     = 3,
  parameter int unsigned ACK_TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reset_pulse_in,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic [2:0]            stage_idx,
  output logic                  busy,
  output logic                  seq_done,
  output logic                  timeout_err
);

  localparam int unsigned MAX_SG  = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
  localparam int unsigned MAX_CNT = (MAX_SG > ACK_TIMEOUT) ? MAX_SG : ACK_TIMEOUT;
  localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [2:0]       LAST_K       = 3'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_WAIT_ACK,
    ST_GAP,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       k_q, k_d;
  logic             timeout_err_q, timeout_err_d;
  logic             ack_cur;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_ASSERT;
      cnt_q         <= '0;
      k_q           <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      k_q           <= k_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    ack_cur = 1'b0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      if (k_q == 3'(i)) ack_cur = stage_ack[i];
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    k_d           = k_q;
    timeout_err_d = timeout_err_q;

    if (reset_pulse_in) begin
      // A new request restarts the sequence from any state, even mid-release.
      state_d = ST_ASSERT;
      cnt_d   = '0;
      k_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_ASSERT: begin
          if (cnt_q == STRETCH_LAST) begin
            state_d = ST_WAIT_ACK;
            cnt_d   = '0;
            k_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_ACK: begin
          if (ack_cur || (cnt_q == TIMEOUT_LAST)) begin
            // A timed-out stage is left released; the sequence carries on.
            if (!ack_cur) timeout_err_d = 1'b1;
            cnt_d   = '0;
            state_d = (k_q == LAST_K) ? ST_DONE : ST_GAP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = ST_WAIT_ACK;
            cnt_d   = '0;
            k_d     = k_q + 3'd1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stage_rst   = '0;
    stage_idx   = k_q;
    busy        = (state_q != ST_IDLE);
    seq_done    = (state_q == ST_DONE) && !reset_pulse_in;
    timeout_err = timeout_err_q;

    case (state_q)
      ST_ASSERT: stage_rst = '1;
      ST_WAIT_ACK, ST_GAP, ST_DONE: begin
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
          stage_rst[i] = (3'(i) > k_q);
        end
      end
      default: stage_idx = 3'd0;
    endcase

    // Block reset forces the power-up view immediately, not one edge later.
    if (reset) begin
      stage_rst   = '1;
      stage_idx   = 3'd0;
      busy        = 1'b1;
      seq_done    = 1'b0;
      timeout_err = 1'b0;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: stretch/stage timing, delayed ack,
// ack timeout, mid-sequence restart, pulse in DONE and block reset.
module tb_reset_sequencer;

  logic       clk;
  logic       reset;
  logic       reset_pulse_in;
  logic [2:0] stage_ack;
  logic [2:0] stage_rst;
  logic [2:0] stage_idx;
  logic       busy;
  logic       seq_done;
  logic       timeout_err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  reset_sequencer #(
    .STRETCH_CYCLES(4),
    .STAGE_GAP     (2),
    .NUM_STAGES    (3),
    .ACK_TIMEOUT   (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .reset_pulse_in(reset_pulse_in),
    .stage_ack     (stage_ack),
    .stage_rst     (stage_rst),
    .stage_idx     (stage_idx),
    .busy          (busy),
    .seq_done      (seq_done),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic at(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk_rst(input string tag, input logic [2:0] exp);
    vectors++;
    assert (stage_rst === exp) else begin
      miscompares++;
      $error("FAIL %s (cycle %0d): stage_rst observed %b expected %b", tag, cyc, stage_rst, exp);
    end
  endtask

  task automatic chk_idx(input string tag, input logic [2:0] exp);
    vectors++;
    assert (stage_idx === exp) else begin
      miscompares++;
      $error("FAIL %s (cycle %0d): stage_idx observed %0d expected %0d", tag, cyc, stage_idx, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s (cycle %0d): observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  // Holds reset for two cycles; cycle 0 is the first cycle with reset low.
  task automatic do_reset();
    reset = 1'b1;
    step();
    #3;
    chk1("rst_terr", timeout_err, 1'b0);
    chk_rst("rst_stage_rst", 3'b111);
    chk1("rst_busy", busy, 1'b1);
    step();
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    reset          = 1'b1;
    reset_pulse_in = 1'b0;
    stage_ack      = 3'b111;

    // Power-up sequence, acks tied high
    do_reset();
    #3; chk_rst("pu_c0", 3'b111); chk1("pu_busy_c0", busy, 1'b1);
        chk1("pu_terr_c0", timeout_err, 1'b0); chk_idx("pu_idx_c0", 3'd0);
    at(3);  #3; chk_rst("pu_c3", 3'b111);
    at(4);  #3; chk_rst("pu_c4", 3'b110); chk_idx("pu_idx_c4", 3'd0);
    at(6);  #3; chk_rst("pu_gap_c6", 3'b110);
    at(7);  #3; chk_rst("pu_c7", 3'b100); chk_idx("pu_idx_c7", 3'd1);
    at(10); #3; chk_rst("pu_c10", 3'b000); chk_idx("pu_idx_c10", 3'd2);
                chk1("pu_done_c10", seq_done, 1'b0);
    at(11); #3; chk1("pu_done_c11", seq_done, 1'b1); chk1("pu_busy_c11", busy, 1'b1);
    at(12); #3; chk1("pu_busy_c12", busy, 1'b0); chk1("pu_done_c12", seq_done, 1'b0);
                chk_idx("pu_idx_c12", 3'd0); chk_rst("pu_c12", 3'b000);

    // Pulse in IDLE at cycle 20
    at(20); reset_pulse_in = 1'b1; #3; chk1("idle_busy_c20", busy, 1'b0);
    at(21); reset_pulse_in = 1'b0; #3; chk_rst("p_c21", 3'b111); chk1("p_busy_c21", busy, 1'b1);
    at(24); #3; chk_rst("p_c24", 3'b111);
    at(25); #3; chk_rst("p_c25", 3'b110);
    at(28); #3; chk_rst("p_c28", 3'b100);
    at(31); #3; chk_rst("p_c31", 3'b000);
    at(32); #3; chk1("p_done_c32", seq_done, 1'b1); chk1("p_terr_c32", timeout_err, 1'b0);
    at(33); #3; chk1("p_busy_c33", busy, 1'b0);

    // Delayed ack on stage 0
    do_reset();
    at(20); stage_ack = 3'b110; reset_pulse_in = 1'b1;
    at(21); reset_pulse_in = 1'b0;
    at(25); #3; chk_rst("dly_c25", 3'b110);
    at(29); stage_ack = 3'b111; #3; chk_rst("dly_c29", 3'b110);
    at(30); #3; chk_rst("dly_gap_c30", 3'b110); chk_idx("dly_idx_c30", 3'd0);
    at(31); #3; chk_rst("dly_gap_c31", 3'b110);
    at(32); #3; chk_rst("dly_c32", 3'b100); chk_idx("dly_idx_c32", 3'd1);

    // Ack timeout on stage 1
    do_reset();
    at(20); stage_ack = 3'b101; reset_pulse_in = 1'b1;
    at(21); reset_pulse_in = 1'b0;
    at(28); #3; chk_rst("to_c28", 3'b100); chk_idx("to_idx_c28", 3'd1);
    at(35); #3; chk1("to_terr_c35", timeout_err, 1'b0); chk_rst("to_c35", 3'b100);
    at(36); #3; chk1("to_terr_c36", timeout_err, 1'b1); chk_rst("to_c36", 3'b100);
    at(38); #3; chk_rst("to_c38", 3'b000);
    at(39); #3; chk1("to_done_c39", seq_done, 1'b1);
    at(45); #3; chk1("to_sticky_c45", timeout_err, 1'b1);
    at(50); reset_pulse_in = 1'b1;
    at(51); reset_pulse_in = 1'b0; #3;
            chk1("to_pulse_keeps_terr", timeout_err, 1'b1); chk_rst("to_c51", 3'b111);

    // Reset mid-sequence with timeout_err set
    at(53); stage_ack = 3'b111; #3; chk1("mr_terr_before", timeout_err, 1'b1);
    do_reset();
    #3; chk_rst("mr_c0", 3'b111); chk1("mr_terr_c0", timeout_err, 1'b0);
    at(4);  #3; chk_rst("mr_c4", 3'b110);
    at(11); #3; chk1("mr_done_c11", seq_done, 1'b1); chk1("mr_terr_c11", timeout_err, 1'b0);

    // Restart mid-sequence
    at(20); reset_pulse_in = 1'b1;
    at(21); reset_pulse_in = 1'b0;
    at(29); reset_pulse_in = 1'b1; #3; chk_idx("rs_idx_c29", 3'd1); chk_rst("rs_c29", 3'b100);
    at(30); reset_pulse_in = 1'b0; #3; chk_rst("rs_c30", 3'b111);
    at(32); #3; chk1("rs_no_done_c32", seq_done, 1'b0); chk_rst("rs_c32", 3'b111);
    at(33); #3; chk_rst("rs_c33", 3'b111);
    at(34); #3; chk_rst("rs_c34", 3'b110);
    at(41); #3; chk1("rs_done_c41", seq_done, 1'b1);

    // Pulse arriving in DONE, then held high for three cycles
    at(50); reset_pulse_in = 1'b1;
    at(51); reset_pulse_in = 1'b0;
    at(62); reset_pulse_in = 1'b1; #3;
            chk1("dn_suppress_c62", seq_done, 1'b0); chk_rst("dn_c62", 3'b000);
            chk1("dn_busy_c62", busy, 1'b1);
    at(63); #3; chk_rst("hold_c63", 3'b111);
    at(65); reset_pulse_in = 1'b0;
    at(68); #3; chk_rst("hold_c68", 3'b111);
    at(69); #3; chk_rst("hold_c69", 3'b110);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
